keypad_responder: RTL
=====================

# keypad_responder

Behavioural responder for the 3x4 matrix keypad. It watches the one-hot `key_col` scan drive from the keypad scanner and answers on `key_row` exactly as a physical keypad would while a commanded key is held. Presses are scripted through a valid/ready command port, with programmable hold time, release gap and contact chatter. It sits in place of the real keypad for bench and self-test builds of the tic-tac-toe game.

## Interface
- `PRESS_CYCLES`, default 500000: clk cycles of stable hold (20 ms at 25 MHz); must be ≥1.
- `GAP_CYCLES`, default 250000: clk cycles of forced release after a press; must be ≥1.
- `BOUNCE_CYCLES`, default 0: chatter cycles at press and at release; 0 disables chatter.
- `CNT_W`, default 24: width of the internal cycle counter; must hold the largest of the three cycle parameters.
- `clk` input 1: system clock, 25 MHz.
- `rst` input 1: reset, asynchronous, active-low.
- `key_col` input 3: column drive from the scanner. Bit0 = column 1 (keys 1,4,7,*), bit1 = column 2 (keys 2,5,8,0), bit2 = column 3 (keys 3,6,9,#).
- `cmd_valid` input 1: a key command is present.
- `cmd_key` input 4: key code. 0–9 are digits, 10 = `*`, 11 = `#`, 12–15 are invalid.
- `cmd_ready` output 1: high only in IDLE.
- `key_row` output 4: row response. Bit0 = top row (1,2,3), bit1 = (4,5,6), bit2 = (7,8,9), bit3 = (*,0,#). Registered.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse when a press/gap sequence completes.
- `err` output 1: one-cycle pulse when an invalid code is accepted.
- `press_count` output 8: number of completed presses; wraps from 255 to 0.

## Operation
- Reset values: state IDLE, `key_row`=0, `busy`=0, `done`=0, `err`=0, `press_count`=0, counter 0, latched key 0.
- Reset asserted mid-press releases `key_row` immediately, through the asynchronous clear.
- A command is accepted on a clk edge where `cmd_valid` and `cmd_ready` are both high. The code is latched on that edge and decoded into a column bit and a row bit.
- Invalid code (12–15): the block pulses `err` on the next cycle and stays in IDLE. `press_count` does not change.
- States and transitions:
  - IDLE: on accepting a valid code, go to BOUNCE_IN if `BOUNCE_CYCLES`>0, otherwise go to HOLD.
  - BOUNCE_IN: lasts `BOUNCE_CYCLES` cycles, then go to HOLD. The contact is "closed" on even counter values and "open" on odd ones, starting closed.
  - HOLD: lasts `PRESS_CYCLES` cycles with the contact closed, then go to BOUNCE_OUT if `BOUNCE_CYCLES`>0, otherwise go to GAP.
  - BOUNCE_OUT: same chatter pattern as BOUNCE_IN, starting open, lasting `BOUNCE_CYCLES` cycles, then go to GAP.
  - GAP: lasts `GAP_CYCLES` cycles with the contact open, then go to IDLE.
- Completion: on the edge that enters IDLE from GAP, pulse `done` and increment `press_count`.
- The counter clears on every state change and increments once per cycle inside a state.
- Row response: next `key_row` = (contact closed AND `key_col` has the latched column bit set) ? latched row one-hot : 4'b0000.
  - `key_col`=000 gives no response.
  - A non-one-hot `key_col` matches whenever the latched column bit is among the bits set.
- `cmd_valid` outside IDLE is ignored; the command is not queued. `cmd_key` is sampled only on the accept edge.

## Timing
- Command accepted at edge N: `busy` and the new state are visible after edge N. `cmd_ready` falls after edge N.
- `key_row` is a one-cycle registered function of (state, `key_col`).
  - With a matching column and `BOUNCE_CYCLES`=0, `key_row` is valid after edge N+1.
  - A `key_col` change at edge M is reflected on `key_row` after edge M+1.
- Contact closed exactly `PRESS_CYCLES` cycles, assuming `key_col` matches continuously.
- Total occupancy from accept to `done` = 2×`BOUNCE_CYCLES` + `PRESS_CYCLES` + `GAP_CYCLES` cycles. `cmd_ready` returns high in the same cycle as `done`.
- Back-to-back commands: a command held valid is accepted on the edge after `done`. No extra idle cycle is inserted.
- `err` asserts one cycle after the accept edge. `cmd_ready` stays high throughout an `err` cycle.

## Test plan
- Test parameters: `PRESS_CYCLES`=8, `GAP_CYCLES`=4, `BOUNCE_CYCLES`=0 unless stated.
- **Key 5, static column.** `key_col`=010 held; command `cmd_key`=5 → `key_row`=0010 for exactly 8 cycles starting at N+1, then 0000; `done` pulses at N+12; `press_count`=1.
- **Key #, cycling scan.** `key_col` cycling 001→010→100 every 3 cycles; command `cmd_key`=11 → `key_row`=1000 only in cycles following `key_col`=100, and 0000 elsewhere.
- **Chatter.** `BOUNCE_CYCLES`=3, `key_col`=001, command `cmd_key`=7 → `key_row` sequence 0100, 0000, 0100, then 0100×8, then 0000, 0100, 0000, then 0000×4; `done` pulses after 18 cycles.
- **Invalid code and busy-time commands.** Command `cmd_key`=13 → `err` pulses once, `busy` stays 0, `press_count` stays 0. Then `cmd_valid` held high with keys 1 then 9 → the second key is accepted only on the `done` edge; `press_count`=2.
- **Reset mid-press.** Assert `rst`=0 during HOLD with `key_row`=0001 → `key_row`=0000, `busy`=0 and `press_count`=0 asynchronously; after release, `cmd_ready`=1.
- **Count wrap.** Issue 256 valid presses → `press_count` wraps to 0 on the 256th `done`.

Source files
------------

// File: rtl/keypad_responder.sv
// keypad_responder -- scripted 3x4 keypad model that answers the scanner's column drive.
// Rev 1.0
`default_nettype none

module keypad_responder #(
  parameter int PRESS_CYCLES  = 500000,
  parameter int GAP_CYCLES    = 250000,
  parameter int BOUNCE_CYCLES = 0,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic [3:0] key_row,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] press_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BIN  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_BOUT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam bit             C_HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] C_PRESS_LAST  = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic [3:0]       key_row_q, key_row_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       press_count_q, press_count_d;

  logic             accept;
  logic             code_ok;
  logic             closed;
  logic [2:0]       col_sel;
  logic [3:0]       row_sel;

  // Keypad geometry: column and row of the latched key.
  always_comb begin
    col_sel = 3'b000;
    row_sel = 4'b0000;
    case (key_q)
      4'd1, 4'd4, 4'd7, 4'd10: col_sel = 3'b001;
      4'd2, 4'd5, 4'd8, 4'd0:  col_sel = 3'b010;
      4'd3, 4'd6, 4'd9, 4'd11: col_sel = 3'b100;
      default:                 col_sel = 3'b000;
    endcase
    case (key_q)
      4'd1, 4'd2, 4'd3:        row_sel = 4'b0001;
      4'd4, 4'd5, 4'd6:        row_sel = 4'b0010;
      4'd7, 4'd8, 4'd9:        row_sel = 4'b0100;
      4'd10, 4'd0, 4'd11:      row_sel = 4'b1000;
      default:                 row_sel = 4'b0000;
    endcase
  end

  always_comb begin
    accept        = cmd_valid && (state_q == S_IDLE);
    code_ok       = (cmd_key < 4'd12);
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    key_d         = accept ? cmd_key : key_q;
    press_count_d = press_count_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && code_ok) state_d = C_HAS_BOUNCE ? S_BIN : S_HOLD;
      end
      S_BIN:  if (cnt_q == C_BOUNCE_LAST) state_d = S_HOLD;
      S_HOLD: if (cnt_q == C_PRESS_LAST)  state_d = C_HAS_BOUNCE ? S_BOUT : S_GAP;
      S_BOUT: if (cnt_q == C_BOUNCE_LAST) state_d = S_GAP;
      S_GAP:  if (cnt_q == C_GAP_LAST)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Chatter closes on even counts going in and on odd counts coming out.
    closed = (state_q == S_HOLD) ||
             ((state_q == S_BIN)  && !cnt_q[0]) ||
             ((state_q == S_BOUT) &&  cnt_q[0]);

    key_row_d = (closed && ((key_col & col_sel) != 3'b000)) ? row_sel : 4'b0000;
    done_d    = (state_q == S_GAP) && (state_d == S_IDLE);
    err_d     = accept && !code_ok;
    if (done_d) press_count_d = press_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      key_q         <= 4'd0;
      key_row_q     <= 4'b0000;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      key_row_q     <= key_row_d;
      done_q        <= done_d;
      err_q         <= err_d;
      press_count_q <= press_count_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign key_row     = key_row_q;
  assign done        = done_q;
  assign err         = err_q;
  assign press_count = press_count_q;

endmodule

`default_nettype wire
